// File: rtl/ssd_pkg.sv
// Shared constants, FSM encoding and the double-dabble step for the seven-segment controller.
// Purely combinational helpers; no state lives here.
package ssd_pkg;

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_RAW_LO = 2'd2;
  localparam logic [1:0] ADDR_RAW_HI = 2'd3;

  localparam logic [1:0] MODE_HEX = 2'd0;
  localparam logic [1:0] MODE_DEC = 2'd1;
  localparam logic [1:0] MODE_RAW = 2'd2;

  localparam logic [5:0]  CHAR_DASH = 6'h3F;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [15:0] DEC_MAX   = 16'd9999;

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_LOAD} conv_state_t;

  // One double-dabble iteration on {bcd[19:0], bin[15:0]}.
  function automatic logic [35:0] dabble_step(input logic [35:0] sr);
    logic [35:0] t;
    t = sr;
    for (int i = 0; i < 5; i++) begin
      if (t[16+4*i +: 4] >= 4'd5) t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
    end
    return {t[34:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 16-bit binary to 5-digit BCD: 16 shift cycles then one LOAD cycle (done).
// start restarts from any state; abort returns to IDLE without producing done.
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);

  conv_state_t state, state_nxt;
  logic [35:0] sr;
  logic [3:0]  count;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)      state_nxt = ST_CONV;
    else if (abort) state_nxt = ST_IDLE;
    else begin
      case (state)
        ST_CONV: if (count == 4'd15) state_nxt = ST_LOAD;
        ST_LOAD: state_nxt = ST_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      count <= '0;
    end else if (start) begin
      sr    <= {20'b0, bin};
      count <= '0;
    end else if (state == ST_CONV) begin
      sr    <= dabble_step(sr);
      count <= count + 4'd1;
    end
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_LOAD);
  end

  assign bcd = sr[35:16];

endmodule

// File: rtl/ssd_ctrl.sv
// CPU-mapped seven-segment formatter: hex/raw update 1 cycle after the write, decimal 17 cycles.
// SSD_CTRL_BLINK_EN adds a free-running blink counter that blanks the display when CTRL[2] is set.
module ssd_ctrl
  import ssd_pkg::*;
#(
  parameter int BLINK_BITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic [31:0] ssd_bits,
  output logic        ssd_char_mode
);

  logic [15:0] value, raw_lo, raw_hi;
  logic [2:0]  ctrl;
  logic [1:0]  mode;
  logic        wr_value, wr_ctrl, conv_start, conv_abort, conv_done, in_range;
  logic [15:0] conv_bin;
  logic [19:0] bcd;
  logic [31:0] bits_q;
  logic        char_q;

  assign mode       = ctrl[1:0];
  assign wr_value   = wr_en && (addr == ADDR_VALUE);
  assign wr_ctrl    = wr_en && (addr == ADDR_CTRL);
  assign conv_start = (wr_value && mode == MODE_DEC) || (wr_ctrl && wr_data[1:0] == MODE_DEC);
  assign conv_abort = wr_ctrl && (wr_data[1:0] != MODE_DEC);
  assign conv_bin   = wr_value ? wr_data : value;
  // Five BCD digits fit 0..65535; anything needing the fifth digit exceeds DEC_MAX.
  assign in_range   = (bcd[19:16] == 4'd0);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .abort (conv_abort),
    .bin   (conv_bin),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      value  <= '0;
      ctrl   <= {1'b0, MODE_HEX};
      raw_lo <= {2{1'b1, SEG_BLANK}};
      raw_hi <= {2{1'b1, SEG_BLANK}};
    end else if (wr_en) begin
      case (addr)
        ADDR_VALUE:  value  <= wr_data;
        ADDR_CTRL:   ctrl   <= wr_data[2:0];
        ADDR_RAW_LO: raw_lo <= wr_data;
        default:     raw_hi <= wr_data;
      endcase
    end
  end

  // A restart on the LOAD edge discards the finished result.
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
      char_q <= 1'b1;
    end else if (conv_done && !conv_start) begin
      bits_q <= in_range ? {4'h0, bcd[15:12], 4'h0, bcd[11:8], 4'h0, bcd[7:4], 4'h0, bcd[3:0]}
                         : {4{2'b00, CHAR_DASH}};
      char_q <= 1'b1;
    end else begin
      case (mode)
        MODE_DEC: bits_q <= bits_q;
        MODE_RAW: begin
          bits_q <= {raw_hi, raw_lo};
          char_q <= 1'b0;
        end
        default: begin
          bits_q <= {4'h0, value[15:12], 4'h0, value[11:8], 4'h0, value[7:4], 4'h0, value[3:0]};
          char_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = value;
    case (addr)
      ADDR_CTRL:   rd_data = {busy, 12'b0, ctrl};
      ADDR_RAW_LO: rd_data = raw_lo;
      ADDR_RAW_HI: rd_data = raw_hi;
      default:     rd_data = value;
    endcase
  end

`ifdef SSD_CTRL_BLINK_EN
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  blank;

  always_ff @(posedge clk) begin
    if (rst) blink_cnt <= '0;
    else     blink_cnt <= blink_cnt + 1'b1;
  end

  assign blank         = ctrl[2] && blink_cnt[BLINK_BITS-1];
  assign ssd_bits      = blank ? {4{1'b1, SEG_BLANK}} : bits_q;
  assign ssd_char_mode = blank ? 1'b0 : char_q;
`else
  assign ssd_bits      = bits_q;
  assign ssd_char_mode = char_q;
`endif

endmodule

// File: tb/tb_ssd_ctrl.sv
// Scoreboard bench for ssd_ctrl: directed test-plan sequence then random register traffic,
// each cycle checked against a behavioural display model.
module tb_ssd_ctrl;

  localparam int BB = 4;

  logic        clk = 1'b0;
  logic        rst, wr_en;
  logic [1:0]  addr;
  logic [15:0] wr_data, rd_data;
  logic        busy, ssd_char_mode;
  logic [31:0] ssd_bits;

  ssd_ctrl #(.BLINK_BITS(BB)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .addr          (addr),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .busy          (busy),
    .ssd_bits      (ssd_bits),
    .ssd_char_mode (ssd_char_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bits;
    logic        cm;
    logic        busy;
    logic [15:0] rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (display content, registers, conversion age in cycles)
  logic [15:0] m_value, m_raw_lo, m_raw_hi;
  logic [2:0]  m_ctrl;
  logic [31:0] m_bits;
  logic        m_cm, m_active, m_valid;
  int          m_age, m_blink;

  initial m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dec_disp(input logic [15:0] v);
    int iv;
    iv = v;
    if (iv > 9999) return 32'h3F3F3F3F;
    return (32'(iv / 1000) << 24) | (32'((iv / 100) % 10) << 16) |
           (32'((iv / 10) % 10) << 8) | 32'(iv % 10);
  endfunction

  function automatic logic [31:0] hex_disp(input logic [15:0] v);
    logic [31:0] r;
    int iv;
    iv = v;
    r = '0;
    for (int i = 0; i < 4; i++) r = r | (32'((iv >> (4 * i)) & 15) << (8 * i));
    return r;
  endfunction

  function automatic exp_t expect_now(input logic [1:0] a);
    exp_t e;
    e.bits = m_bits;
    e.cm   = m_cm;
`ifdef SSD_CTRL_BLINK_EN
    if (m_ctrl[2] && (((m_blink >> (BB - 1)) & 1) == 1)) begin
      e.bits = 32'hFFFFFFFF;
      e.cm   = 1'b0;
    end
`endif
    e.busy = m_active;
    case (a)
      2'd0:    e.rd = m_value;
      2'd1:    e.rd = {m_active, 12'b0, m_ctrl};
      2'd2:    e.rd = m_raw_lo;
      default: e.rd = m_raw_hi;
    endcase
    return e;
  endfunction

  // Advance the model across one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic w, input logic [1:0] a, input logic [15:0] d);
    logic trig, leave;
    if (r) begin
      m_value = '0; m_ctrl = '0; m_raw_lo = 16'hFFFF; m_raw_hi = 16'hFFFF;
      m_bits = '0; m_cm = 1'b1; m_active = 1'b0; m_age = 0; m_blink = 0;
      return;
    end
    trig  = w && ((a == 2'd0 && m_ctrl[1:0] == 2'd1) || (a == 2'd1 && d[1:0] == 2'd1));
    leave = w && a == 2'd1 && d[1:0] != 2'd1;
    if (m_active && m_age == 16 && !trig) begin
      m_bits = dec_disp(m_value);
      m_cm   = 1'b1;
    end else if (m_ctrl[1:0] == 2'd2) begin
      m_bits = {m_raw_hi, m_raw_lo};
      m_cm   = 1'b0;
    end else if (m_ctrl[1:0] != 2'd1) begin
      m_bits = hex_disp(m_value);
      m_cm   = 1'b1;
    end
    if (trig) begin
      m_active = 1'b1;
      m_age    = 0;
    end else if (leave) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_age++;
      if (m_age == 17) m_active = 1'b0;
    end
    if (w) begin
      case (a)
        2'd0:    m_value  = d;
        2'd1:    m_ctrl   = d[2:0];
        2'd2:    m_raw_lo = d;
        default: m_raw_hi = d;
      endcase
    end
    m_blink++;
  endtask

  task automatic cyc(input logic r, input logic w, input logic [1:0] a, input logic [15:0] d);
    rst = r; wr_en = w; addr = a; wr_data = d;
    if (m_valid) sb.push_back(expect_now(a));
    @(posedge clk);
    model_edge(r, w, a, d);
    if (r) m_valid = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'($urandom_range(0, 3)), 16'h0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ssd_bits", ssd_bits, e.bits);
      chk("ssd_char_mode", 32'(ssd_char_mode), 32'(e.cm));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("rd_data", 32'(rd_data), 32'(e.rd));
    end
  end

  initial begin
    logic [1:0]  a;
    logic [15:0] d;
    #1;
    repeat (3) cyc(1'b1, 1'b0, 2'd0, 16'h0);
    cyc(1'b0, 1'b0, 2'd1, 16'h0);
    chk("reset_bits", ssd_bits, 32'h0);
    chk("reset_char_mode", 32'(ssd_char_mode), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rd_ctrl", 32'(rd_data), 32'd0);

    cyc(1'b0, 1'b1, 2'd0, 16'hBEEF); idle(1);
    chk("hex_beef", ssd_bits, 32'h0B0E0E0F);

    cyc(1'b0, 1'b1, 2'd1, 16'd1); cyc(1'b0, 1'b1, 2'd0, 16'd1234);
    idle(16);
    chk("dec1234_busy_n16", 32'(busy), 32'd1);
    idle(1);
    chk("dec1234_busy_n17", 32'(busy), 32'd0);
    chk("dec1234_bits", ssd_bits, 32'h01020304);

    cyc(1'b0, 1'b1, 2'd0, 16'd10000); idle(17);
    chk("dec10000_dashes", ssd_bits, 32'h3F3F3F3F);
    cyc(1'b0, 1'b1, 2'd0, 16'd9999); idle(17);
    chk("dec9999", ssd_bits, 32'h09090909);

    cyc(1'b0, 1'b1, 2'd0, 16'd5); idle(8);
    cyc(1'b0, 1'b1, 2'd0, 16'd42);
    chk("restart_hold", ssd_bits, 32'h09090909);
    idle(16);
    chk("restart_busy_n16", 32'(busy), 32'd1);
    idle(1);
    chk("restart_bits", ssd_bits, 32'h00000402);

    cyc(1'b0, 1'b1, 2'd2, 16'h4079); cyc(1'b0, 1'b1, 2'd3, 16'h2430);
    cyc(1'b0, 1'b1, 2'd1, 16'd2); idle(1);
    chk("raw_bits", ssd_bits, 32'h24304079);
    chk("raw_char_mode", 32'(ssd_char_mode), 32'd0);

    cyc(1'b0, 1'b1, 2'd1, 16'd6); idle(40);

    for (int n = 0; n < 3000; n++) begin
      a = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       d = 16'($urandom_range(9990, 10010));
        1:       d = 16'($urandom_range(0, 99));
        default: d = 16'($urandom);
      endcase
      if (a == 2'd1) d = {13'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3) == 0 ? 2 : $urandom_range(0, 3))};
      cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 5) == 0), a, d);
      if (n % 150 == 0) idle(20);
    end

    idle(3);
    rst = 1'b0; wr_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
